// File: rtl/ad9122_ctrl_defs.sv
// Shared definitions for the AD9122 DCI delay controller.
// Sweep states exist only when AD9122_DCI_SWEEP_EN is defined.
package ad9122_ctrl_defs;
  localparam int TAP_W = 5;
  localparam int NUM_TAPS = 32;
  localparam logic [7:0] REG_LOAD = 8'd0;
  localparam logic [7:0] REG_SWEEP = 8'd1;

`ifdef AD9122_DCI_SWEEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CLEAR,
    S_DWELL, S_RECORD, S_SCAN, S_APPLY
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_SETTLE
  } state_t;
`endif
endpackage

// File: rtl/dci_window_finder.sv
// Serial scanner: finds the longest linear run of 1s in a 32-bit
// pass map, one bit per clock; ties keep the lowest start index.
module dci_window_finder
  import ad9122_ctrl_defs::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_TAPS-1:0] map,
  output logic                done,
  output logic [TAP_W:0]      len,
  output logic [TAP_W-1:0]    start_idx
);
  logic             busy;
  logic [TAP_W-1:0] idx;
  logic [TAP_W:0]   cur_len;
  logic [TAP_W-1:0] cur_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
      cur_len   <= '0;
      cur_start <= '0;
      len       <= '0;
      start_idx <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy      <= 1'b1;
        idx       <= '0;
        cur_len   <= '0;
        cur_start <= '0;
        len       <= '0;
        start_idx <= '0;
      end else if (busy) begin
        if (map[idx]) begin
          if (cur_len == '0) cur_start <= idx;
          cur_len <= cur_len + 1'b1;
          // strict compare keeps the earliest of equal runs
          if (cur_len + 1'b1 > len) begin
            len       <= cur_len + 1'b1;
            start_idx <= (cur_len == '0) ? idx : cur_start;
          end
        end else begin
          cur_len <= '0;
        end
        idx <= idx + 1'b1;
        if (idx == TAP_W'(NUM_TAPS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ad9122_dci_delay_ctrl.sv
// AD9122 DCI lane delay sequencer: tap loads and, with
// AD9122_DCI_SWEEP_EN defined, a SED-driven tap sweep and centring.
module ad9122_dci_delay_ctrl
  import ad9122_ctrl_defs::*;
#(
  parameter int BASE          = 0,
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_stb,
  input  logic [7:0]          set_addr,
  input  logic [31:0]         set_data,
  input  logic                sed_err,
  output logic                sed_clear,
  output logic [TAP_W-1:0]    delay_value,
  output logic                delay_reset,
  output logic                busy,
  output logic                done,
  output logic                cal_ok,
  output logic [TAP_W-1:0]    cal_tap,
  output logic [NUM_TAPS-1:0] pass_map
);
  localparam int CMAX = (SETTLE_CYCLES > DWELL_CYCLES) ?
                        SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [7:0] A_LOAD  = 8'(BASE) + REG_LOAD;
  localparam logic [7:0] A_SWEEP = 8'(BASE) + REG_SWEEP;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load_wr;
  logic          sweep_wr;

  assign load_wr  = set_stb && (set_addr == A_LOAD);
  assign sweep_wr = set_stb && (set_addr == A_SWEEP) && set_data[0];
  assign busy     = (state != S_IDLE);

`ifdef AD9122_DCI_SWEEP_EN
  logic                sweeping;
  logic [TAP_W-1:0]    tap;
  logic [TAP_W-1:0]    saved;
  logic                err;
  logic [NUM_TAPS-1:0] work;
  logic                scan_start;
  logic                win_done;
  logic [TAP_W:0]      win_len;
  logic [TAP_W-1:0]    win_start;
  logic                unused_ok;

  assign unused_ok = ^set_data[31:TAP_W];

  dci_window_finder u_finder (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (scan_start),
    .map       (work),
    .done      (win_done),
    .len       (win_len),
    .start_idx (win_start)
  );
`else
  logic unused_ok;

  assign unused_ok = ^{set_data[31:TAP_W], sed_err, sweep_wr};
  assign sed_clear = 1'b0;
  assign cal_ok    = 1'b0;
  assign cal_tap   = '0;
  assign pass_map  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      delay_value <= '0;
      delay_reset <= 1'b0;
      done        <= 1'b0;
`ifdef AD9122_DCI_SWEEP_EN
      sed_clear   <= 1'b0;
      cal_ok      <= 1'b0;
      cal_tap     <= '0;
      pass_map    <= '0;
      sweeping    <= 1'b0;
      tap         <= '0;
      saved       <= '0;
      err         <= 1'b0;
      work        <= '0;
      scan_start  <= 1'b0;
`endif
    end else begin
      delay_reset <= 1'b0;
      done        <= 1'b0;
`ifdef AD9122_DCI_SWEEP_EN
      sed_clear   <= 1'b0;
      scan_start  <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (load_wr) begin
            delay_value <= set_data[TAP_W-1:0];
            state       <= S_LOAD;
          end
`ifdef AD9122_DCI_SWEEP_EN
          else if (sweep_wr) begin
            saved       <= delay_value;
            delay_value <= '0;
            tap         <= '0;
            work        <= '0;
            pass_map    <= '0;
            sweeping    <= 1'b1;
            state       <= S_LOAD;
          end
`endif
        end
        S_LOAD: begin
          delay_reset <= 1'b1;
          cnt         <= CW'(SETTLE_CYCLES);
          state       <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
`ifdef AD9122_DCI_SWEEP_EN
          else if (sweeping) begin
            sed_clear <= 1'b1;
            state     <= S_CLEAR;
          end
`endif
          else begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
`ifdef AD9122_DCI_SWEEP_EN
        S_CLEAR: begin
          // SED may still reflect the previous tap here
          err   <= 1'b0;
          cnt   <= CW'(DWELL_CYCLES - 1);
          state <= S_DWELL;
        end
        S_DWELL: begin
          err <= err | sed_err;
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= S_RECORD;
        end
        S_RECORD: begin
          work[tap] <= ~err;
          if (tap == TAP_W'(NUM_TAPS - 1)) begin
            scan_start <= 1'b1;
            state      <= S_SCAN;
          end else begin
            tap         <= tap + 1'b1;
            delay_value <= tap + 1'b1;
            state       <= S_LOAD;
          end
        end
        S_SCAN: begin
          if (win_done) begin
            pass_map <= work;
            sweeping <= 1'b0;
            if (win_len != '0) begin
              cal_ok  <= 1'b1;
              cal_tap <= win_start +
                         TAP_W'((win_len - 1'b1) >> 1);
            end else begin
              cal_ok <= 1'b0;
            end
            state <= S_APPLY;
          end
        end
        S_APPLY: begin
          delay_value <= cal_ok ? cal_tap : saved;
          state       <= S_LOAD;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ad9122_dci_delay_ctrl.sv
// Bench for ad9122_dci_delay_ctrl: vector table plus scoreboard,
// sweep rows active when AD9122_DCI_SWEEP_EN is defined.
module tb_ad9122_dci_delay_ctrl;
  localparam int S = 4;
  localparam int D = 8;
  localparam logic [7:0] BASE = 8'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        sed_err;
  logic        sed_clear;
  logic [4:0]  delay_value;
  logic        delay_reset;
  logic        busy;
  logic        done;
  logic        cal_ok;
  logic [4:0]  cal_tap;
  logic [31:0] pass_map;
  logic [31:0] fail_mask = '0;

  always #5 clk = ~clk;
  assign sed_err = fail_mask[delay_value];

  ad9122_dci_delay_ctrl #(
    .BASE          (16),
    .SETTLE_CYCLES (S),
    .DWELL_CYCLES  (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .sed_err     (sed_err),
    .sed_clear   (sed_clear),
    .delay_value (delay_value),
    .delay_reset (delay_reset),
    .busy        (busy),
    .done        (done),
    .cal_ok      (cal_ok),
    .cal_tap     (cal_tap),
    .pass_map    (pass_map)
  );

  typedef struct {
    logic [4:0]  dv;
    logic        ok;
    logic [4:0]  tap;
    logic [31:0] map;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          sweep;
    logic [31:0] data;
    logic [4:0]  dv;
    logic        ok;
    logic [4:0]  tap;
    logic [31:0] map;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  exp_t e_mon;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes = 0;
  int clears = 0;
  int dones = 0;
  int wr_cyc;
  logic [4:0]  prev_dv = '0;
  logic [4:0]  m_dv = '0;
  logic        m_ok = 1'b0;
  logic [4:0]  m_tap = '0;
  logic [31:0] m_map = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (delay_reset) begin
        strobes++;
        chk("dv_stable_before_strobe", 32'(delay_value),
            32'(prev_dv));
      end
      if (sed_clear) clears++;
      if (done) begin
        dones++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e_mon = sb.pop_front();
          chk("done_value", 32'(delay_value), 32'(e_mon.dv));
          chk("done_cal_ok", 32'(cal_ok), 32'(e_mon.ok));
          chk("done_cal_tap", 32'(cal_tap), 32'(e_mon.tap));
          chk("done_pass_map", pass_map, e_mon.map);
          chk("done_busy_low", 32'(busy), 32'd0);
          if (e_mon.cyc >= 0)
            chk("done_cycle", 32'(cyc), 32'(e_mon.cyc));
        end
      end
    end
    prev_dv = delay_value;
  end

  task automatic write(logic [7:0] a, logic [31:0] d);
    @(posedge clk);
    #1;
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
    wr_cyc  = cyc;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout: busy=%0b pending=%0d",
               busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_load(logic [4:0] t);
    exp_t e;
    write(BASE, 32'(t));
    e = '{t, m_ok, m_tap, m_map, wr_cyc + S + 2};
    sb.push_back(e);
    m_dv = t;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_value_early", 32'(delay_value), 32'(t));
    chk("load_no_strobe_yet", 32'(delay_reset), 32'd0);
    @(posedge clk);
    #1;
    chk("load_strobe", 32'(delay_reset), 32'd1);
  endtask

  task automatic do_sweep(vec_t v);
    exp_t e;
    int c0 = clears;
    int s0 = strobes;
    fail_mask = v.data;
    write(BASE + 8'd1, 32'd1);
    chk("sweep_busy", 32'(busy), 32'd1);
    chk("sweep_map_cleared", pass_map, 32'd0);
    e = '{v.dv, v.ok, v.tap, v.map, -1};
    sb.push_back(e);
    m_dv  = v.dv;
    m_ok  = v.ok;
    m_tap = v.tap;
    m_map = v.map;
    wait_idle(2000);
    chk("sweep_clear_count", 32'(clears - c0), 32'd32);
    chk("sweep_strobe_count", 32'(strobes - s0), 32'd33);
  endtask

  task automatic chk_zero(string name);
    chk(name, {sed_clear, delay_value, delay_reset, busy,
               done, cal_ok, cal_tap}, 32'd0);
    chk({name, "_map"}, pass_map, 32'd0);
  endtask

  initial begin
    int d0;
    int s0;
    int c0;
    int n;
    bit seen;

    vt.push_back('{0, 32'd17, 5'd17, 1'b0, 5'd0, 32'd0});
    vt.push_back('{0, 32'd0,  5'd0,  1'b0, 5'd0, 32'd0});
    vt.push_back('{0, 32'd31, 5'd31, 1'b0, 5'd0, 32'd0});
`ifdef AD9122_DCI_SWEEP_EN
    vt.push_back('{1, 32'hFFF003FF, 5'd14, 1'b1, 5'd14, 32'h000FFC00});
    vt.push_back('{1, 32'hFFFFC3C3, 5'd3,  1'b1, 5'd3,  32'h00003C3C});
    vt.push_back('{0, 32'd22, 5'd22, 1'b0, 5'd0, 32'd0});
    vt.push_back('{1, 32'hFFFFFFFF, 5'd22, 1'b0, 5'd3,  32'h00000000});
    vt.push_back('{1, 32'h00000000, 5'd15, 1'b1, 5'd15, 32'hFFFFFFFF});
    vt.push_back('{1, 32'h7FFFFFFF, 5'd31, 1'b1, 5'd31, 32'h80000000});
    vt.push_back('{1, 32'hFFFFFFFE, 5'd0,  1'b1, 5'd0,  32'h00000001});
    vt.push_back('{1, 32'hFFFFFF3F, 5'd6,  1'b1, 5'd6,  32'h000000C0});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      if (vt[i].sweep) do_sweep(vt[i]);
      else do_load(vt[i].data[4:0]);
      wait_idle(2000);
      chk("idle_value", 32'(delay_value), 32'(vt[i].dv));
    end

    write(BASE + 8'd2, 32'd3);
    chk("other_addr_ignored", 32'(busy), 32'd0);
    write(8'h00, 32'd7);
    chk("base_offset_ignored", 32'(busy), 32'd0);

    do_load(5'd5);
    wait_idle(100);
    d0 = dones;
    do_load(5'd5);
    write(BASE, 32'd9);
    write(BASE + 8'd1, 32'd1);
    wait_idle(100);
    repeat (5) @(negedge clk);
    #1;
    chk("busy_drop_one_done", 32'(dones - d0), 32'd1);
    chk("busy_drop_value", 32'(delay_value), 32'd5);
    chk("busy_drop_idle", 32'(busy), 32'd0);

`ifdef AD9122_DCI_SWEEP_EN
    fail_mask = '0;
    write(BASE + 8'd1, 32'd1);
    sb.push_back('{5'd0, 1'b0, 5'd0, 32'd0, -1});
    n = 0;
    while (!(sed_clear && delay_value == 5'd12) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL reach_tap12_timeout: dv=%0d", delay_value);
    end
    repeat (3) @(posedge clk);
`else
    write(BASE, 32'd20);
    sb.push_back('{5'd20, 1'b0, 5'd0, 32'd0, -1});
    @(posedge clk);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk_zero("abort_outputs");
    m_dv = '0; m_ok = 1'b0; m_tap = '0; m_map = '0;
    s0 = strobes;
    c0 = clears;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_strobe", 32'(strobes - s0), 32'd0);
    chk("abort_no_clear", 32'(clears - c0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    do_load(5'd7);
    wait_idle(100);
    chk("after_abort_value", 32'(delay_value), 32'd7);

`ifndef AD9122_DCI_SWEEP_EN
    s0 = strobes;
    c0 = clears;
    seen = 1'b0;
    write(BASE + 8'd1, 32'd1);
    repeat (10) begin
      @(negedge clk);
      seen = seen | busy;
    end
    chk("sweep_disabled_busy", 32'(seen), 32'd0);
    chk("sweep_disabled_strobes", 32'(strobes - s0), 32'd0);
    chk("sweep_disabled_clears", 32'(clears - c0), 32'd0);
    chk("sweep_disabled_cal",
        {pass_map[26:0], cal_ok, cal_tap[3:0]}, 32'd0);
`else
    seen = 1'b0;
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
